// File: rtl/fifo_pkg.sv
// Shared constants, pointer type and occupancy helper for the 16-entry synchronous FIFO.
package fifo_pkg;

    localparam int FIFO_ADDR_W = 4;
    localparam int FIFO_PTR_W  = 5;
    localparam int FIFO_DEPTH  = 16;

    typedef logic [FIFO_PTR_W-1:0] fifo_ptr_t;

    // Pointers carry a wrap bit, so a plain modular difference yields 0..FIFO_DEPTH.
    function automatic fifo_ptr_t fifo_occupancy(input fifo_ptr_t wr, input fifo_ptr_t rd);
        return wr - rd;
    endfunction

endpackage

// File: rtl/fifo_ptr_compare.sv
// Combinational occupancy, full and almost-full from a write/read pointer pair.
module fifo_ptr_compare
    import fifo_pkg::*;
#(
    parameter int ADDR_W    = FIFO_ADDR_W,
    parameter int AF_MARGIN = 2
) (
    input  logic [ADDR_W:0] wr_ptr,
    input  logic [ADDR_W:0] rd_ptr,
    output logic            full,
    output logic            almost_full
);

    localparam int PTR_W = ADDR_W + 1;
    localparam logic [ADDR_W:0] AF_THRESH = PTR_W'((2 ** ADDR_W) - AF_MARGIN);

    logic [ADDR_W:0] occupancy;

    generate
        if ((ADDR_W == FIFO_ADDR_W) && (PTR_W == FIFO_PTR_W) && ((2 ** ADDR_W) == FIFO_DEPTH)) begin : g_pkg_occ
            assign occupancy = fifo_occupancy(wr_ptr, rd_ptr);
        end else begin : g_generic_occ
            assign occupancy = wr_ptr - rd_ptr;
        end
    endgenerate

    // Same address with opposite wrap bits means the writer is one lap ahead.
    assign full        = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                         (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign almost_full = (occupancy >= AF_THRESH);

endmodule

// File: rtl/fifo_input_control.sv
// Write-side control of the 16-entry FIFO: registers memory writes, keeps the write pointer.
// Optional registered occupancy output 'level' is enabled with `define FIFO_WR_LEVEL_EN.
module fifo_input_control
    import fifo_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = FIFO_ADDR_W,
    parameter int AF_MARGIN = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              write_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic [ADDR_W:0]   rd_ptr,
    output logic              write_en_o,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W:0]   wr_ptr,
    output logic              full,
    output logic              almost_full,
    output logic              overflow
`ifdef FIFO_WR_LEVEL_EN
    ,
    output logic [ADDR_W:0]   level
`endif
);

    logic accept;

    fifo_ptr_compare #(
        .ADDR_W    (ADDR_W),
        .AF_MARGIN (AF_MARGIN)
    ) u_compare (
        .wr_ptr      (wr_ptr),
        .rd_ptr      (rd_ptr),
        .full        (full),
        .almost_full (almost_full)
    );

    // No look-ahead on rd_ptr: a read landing in the same cycle does not free a slot yet.
    assign accept = write_en && !full;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            write_en_o <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            wr_ptr     <= '0;
            overflow   <= 1'b0;
        end else if (accept) begin
            write_en_o <= 1'b1;
            wr_addr    <= wr_ptr[ADDR_W-1:0];
            wr_data    <= data_in;
            wr_ptr     <= wr_ptr + 1'b1;
            overflow   <= 1'b0;
        end else begin
            write_en_o <= 1'b0;
            overflow   <= write_en;
        end
    end

`ifdef FIFO_WR_LEVEL_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level <= '0;
        end else begin
            level <= wr_ptr - rd_ptr;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_input_control.sv
// Directed testbench for fifo_input_control: fill, overflow, wrap, read/write collisions, async reset.
module tb_fifo_input_control;

    logic       clk;
    logic       reset_n;
    logic       write_en;
    logic [7:0] data_in;
    logic [4:0] rd_ptr;
    logic       write_en_o;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic [4:0] wr_ptr;
    logic       full;
    logic       almost_full;
    logic       overflow;
`ifdef FIFO_WR_LEVEL_EN
    logic [4:0] level;
`endif

    int vectors;
    int miscompares;

    fifo_input_control #(
        .DATA_W    (8),
        .ADDR_W    (4),
        .AF_MARGIN (2)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .write_en    (write_en),
        .data_in     (data_in),
        .rd_ptr      (rd_ptr),
        .write_en_o  (write_en_o),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_ptr      (wr_ptr),
        .full        (full),
        .almost_full (almost_full),
        .overflow    (overflow)
`ifdef FIFO_WR_LEVEL_EN
        ,
        .level       (level)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        write_en = 1'b0;
        data_in  = 8'h00;
        rd_ptr   = 5'd0;
        step();
        step();
        reset_n = 1'b1;
        step();
        vectors++;
        if (wr_ptr !== 5'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_wr_ptr: got %0d expected 0", wr_ptr);
        end
        vectors++;
        if (full !== 1'b0 || almost_full !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_flags: got full=%b af=%b expected 0/0", full, almost_full);
        end
        vectors++;
        if (write_en_o !== 1'b0 || overflow !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_strobes: got we_o=%b ovf=%b expected 0/0", write_en_o, overflow);
        end
        vectors++;
        if (wr_addr !== 4'd0 || wr_data !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL reset_bus: got addr=%0d data=%h expected 0/00", wr_addr, wr_data);
        end
    endtask

    task automatic test_fill();
        logic [4:0] exp_ptr;
        for (int i = 0; i < 16; i++) begin
            write_en = 1'b1;
            data_in  = 8'(i);
            step();
            exp_ptr = 5'(i + 1);
            vectors++;
            if (write_en_o !== 1'b1 || wr_addr !== 4'(i) || wr_data !== 8'(i)) begin
                miscompares++;
                $display("[TB] FAIL fill_write[%0d]: got we_o=%b addr=%0d data=%h expected 1/%0d/%h",
                         i, write_en_o, wr_addr, wr_data, i, i);
            end
            vectors++;
            if (wr_ptr !== exp_ptr) begin
                miscompares++;
                $display("[TB] FAIL fill_ptr[%0d]: got %0d expected %0d", i, wr_ptr, exp_ptr);
            end
            vectors++;
            if (almost_full !== (i >= 13) || full !== (i == 15)) begin
                miscompares++;
                $display("[TB] FAIL fill_flags[%0d]: got af=%b full=%b expected %b/%b",
                         i, almost_full, full, (i >= 13), (i == 15));
            end
        end
    endtask

    task automatic test_overflow();
        write_en = 1'b1;
        data_in  = 8'hAA;
        for (int i = 0; i < 2; i++) begin
            step();
            vectors++;
            if (overflow !== 1'b1 || write_en_o !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL ovf_strobe[%0d]: got ovf=%b we_o=%b expected 1/0", i, overflow, write_en_o);
            end
            vectors++;
            if (wr_ptr !== 5'd16 || wr_data !== 8'h0F || wr_addr !== 4'd15) begin
                miscompares++;
                $display("[TB] FAIL ovf_hold[%0d]: got ptr=%0d data=%h addr=%0d expected 16/0f/15",
                         i, wr_ptr, wr_data, wr_addr);
            end
        end
`ifdef FIFO_WR_LEVEL_EN
        vectors++;
        if (level !== 5'd16) begin
            miscompares++;
            $display("[TB] FAIL ovf_level: got %0d expected 16", level);
        end
`endif
        write_en = 1'b0;
        step();
        vectors++;
        if (overflow !== 1'b0 || wr_ptr !== 5'd16) begin
            miscompares++;
            $display("[TB] FAIL ovf_idle: got ovf=%b ptr=%0d expected 0/16", overflow, wr_ptr);
        end
    endtask

    task automatic test_wrap();
        rd_ptr = 5'd1;
        #1;
        vectors++;
        if (full !== 1'b0 || almost_full !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL wrap_unfull: got full=%b af=%b expected 0/1", full, almost_full);
        end
        write_en = 1'b1;
        data_in  = 8'h55;
        step();
        vectors++;
        if (write_en_o !== 1'b1 || wr_addr !== 4'd0 || wr_data !== 8'h55 || wr_ptr !== 5'd17 || full !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL wrap_first: got we_o=%b addr=%0d data=%h ptr=%0d full=%b expected 1/0/55/17/1",
                     write_en_o, wr_addr, wr_data, wr_ptr, full);
        end
        for (int j = 2; j <= 16; j++) begin
            rd_ptr  = 5'(j);
            data_in = 8'(8'h60 + j);
            step();
            vectors++;
            if (wr_ptr !== 5'((16 + j) % 32) || wr_addr !== 4'((15 + j) % 16) || write_en_o !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL wrap_step[%0d]: got ptr=%0d addr=%0d we_o=%b expected %0d/%0d/1",
                         j, wr_ptr, wr_addr, write_en_o, (16 + j) % 32, (15 + j) % 16);
            end
        end
        vectors++;
        if (wr_ptr !== 5'd0 || full !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL wrap_end: got ptr=%0d full=%b expected 0/1", wr_ptr, full);
        end
        write_en = 1'b0;
    endtask

    task automatic test_rd_wr_not_full();
        rd_ptr   = 5'd18;
        write_en = 1'b1;
        data_in  = 8'h21;
        step();
        rd_ptr  = 5'd19;
        data_in = 8'h22;
        step();
        vectors++;
        if (wr_ptr !== 5'd2 || full !== 1'b0 || almost_full !== 1'b1 || wr_addr !== 4'd1) begin
            miscompares++;
            $display("[TB] FAIL rdwr_steady: got ptr=%0d full=%b af=%b addr=%0d expected 2/0/1/1",
                     wr_ptr, full, almost_full, wr_addr);
        end
        data_in = 8'h23;
        step();
        vectors++;
        if (wr_ptr !== 5'd3 || full !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL rdwr_fill: got ptr=%0d full=%b expected 3/1", wr_ptr, full);
        end
    endtask

    task automatic test_read_while_full();
        write_en = 1'b1;
        data_in  = 8'h77;
        @(posedge clk);
        #1;
        rd_ptr = 5'd20;
        vectors++;
        if (overflow !== 1'b1 || write_en_o !== 1'b0 || wr_ptr !== 5'd3) begin
            miscompares++;
            $display("[TB] FAIL collide_reject: got ovf=%b we_o=%b ptr=%0d expected 1/0/3",
                     overflow, write_en_o, wr_ptr);
        end
        step();
        vectors++;
        if (overflow !== 1'b0 || write_en_o !== 1'b1 || wr_ptr !== 5'd4 || wr_addr !== 4'd3 || wr_data !== 8'h77) begin
            miscompares++;
            $display("[TB] FAIL collide_retry: got ovf=%b we_o=%b ptr=%0d addr=%0d data=%h expected 0/1/4/3/77",
                     overflow, write_en_o, wr_ptr, wr_addr, wr_data);
        end
        write_en = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        reset_n = 1'b0;
        rd_ptr  = 5'd0;
        #2;
        reset_n = 1'b1;
        step();
        write_en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            data_in = 8'(8'h30 + i);
            step();
        end
        vectors++;
        if (wr_ptr !== 5'd7 || write_en_o !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL burst_pre: got ptr=%0d we_o=%b expected 7/1", wr_ptr, write_en_o);
        end
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if (write_en_o !== 1'b0 || wr_ptr !== 5'd0 || overflow !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL burst_reset: got we_o=%b ptr=%0d ovf=%b expected 0/0/0",
                     write_en_o, wr_ptr, overflow);
        end
`ifdef FIFO_WR_LEVEL_EN
        vectors++;
        if (level !== 5'd0) begin
            miscompares++;
            $display("[TB] FAIL burst_level: got %0d expected 0", level);
        end
`endif
        write_en = 1'b0;
        step();
        reset_n = 1'b1;
        step();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_fill();
        test_overflow();
        test_wrap();
        test_rd_wr_not_full();
        test_read_while_full();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
